// File: rtl/full_adder_behavioral_if.sv
// Operand/result bundle for full_adder_behavioral.
// FA_OVF_EN adds the signed-overflow signals ovf/ovf_q.
interface full_adder_behavioral_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             en;
  logic [WIDTH-1:0] s;
  logic             co;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             q_valid;
`ifdef FA_OVF_EN
  logic             ovf;
  logic             ovf_q;

  modport master (
    output a, b, ci, en,
    input  s, co, s_q, co_q, q_valid, ovf, ovf_q
  );

  modport slave (
    input  a, b, ci, en,
    output s, co, s_q, co_q, q_valid, ovf, ovf_q
  );
`else
  modport master (
    output a, b, ci, en,
    input  s, co, s_q, co_q, q_valid
  );

  modport slave (
    input  a, b, ci, en,
    output s, co, s_q, co_q, q_valid
  );
`endif
endinterface

// File: rtl/full_adder_behavioral.sv
// WIDTH-bit adder: combinational {co,s} plus a registered copy.
// FA_OVF_EN adds signed overflow (ovf) and its registered copy.
module full_adder_behavioral #(
  parameter int WIDTH = 1
) (
  input logic                     clk,
  input logic                     rst,
  full_adder_behavioral_if.slave  bus
);

  logic [WIDTH:0] sum;
  logic           c_msb;

  // Zero-extended add keeps the carry-out in the top bit
  always_comb begin
    sum = {1'b0, bus.a} + {1'b0, bus.b}
        + {{WIDTH{1'b0}}, bus.ci};
  end

  // Carry into the MSB recovered from the MSB sum bit
  assign c_msb = bus.a[WIDTH-1] ^ bus.b[WIDTH-1]
               ^ sum[WIDTH-1];

  assign bus.s  = sum[WIDTH-1:0];
  assign bus.co = sum[WIDTH];

`ifdef FA_OVF_EN
  assign bus.ovf = sum[WIDTH] ^ c_msb;

  // Capture result on en; rst clears and wins over en
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s_q     <= '0;
      bus.co_q    <= 1'b0;
      bus.ovf_q   <= 1'b0;
      bus.q_valid <= 1'b0;
    end else if (bus.en) begin
      bus.s_q     <= sum[WIDTH-1:0];
      bus.co_q    <= sum[WIDTH];
      bus.ovf_q   <= sum[WIDTH] ^ c_msb;
      bus.q_valid <= 1'b1;
    end
  end
`else
  logic unused_c_msb;
  assign unused_c_msb = c_msb;

  // Capture result on en; rst clears and wins over en
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s_q     <= '0;
      bus.co_q    <= 1'b0;
      bus.q_valid <= 1'b0;
    end else if (bus.en) begin
      bus.s_q     <= sum[WIDTH-1:0];
      bus.co_q    <= sum[WIDTH];
      bus.q_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_behavioral.sv
// Directed bench for full_adder_behavioral at WIDTH=1 and WIDTH=8.
// FA_OVF_EN enables the overflow checks.
`timescale 1ns/1ps
module tb_full_adder_behavioral;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  full_adder_behavioral_if #(.WIDTH(1)) f1 ();
  full_adder_behavioral_if #(.WIDTH(8)) f8 ();

  full_adder_behavioral #(.WIDTH(1)) u_w1 (
    .clk (clk),
    .rst (rst),
    .bus (f1)
  );

  full_adder_behavioral #(.WIDTH(8)) u_w8 (
    .clk (clk),
    .rst (rst),
    .bus (f8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] s_tab;
  logic [7:0] c_tab;

  initial begin
    total = 0;
    bad   = 0;
    // hand truth table indexed by {a,b,ci}
    s_tab = 8'b1001_0110;
    c_tab = 8'b1110_1000;
    rst   = 1'b1;
    f1.a = 1'b0; f1.b = 1'b0; f1.ci = 1'b0; f1.en = 1'b0;
    f8.a = 8'h00; f8.b = 8'h00; f8.ci = 1'b0; f8.en = 1'b0;

    tick();
    tick();
    chk("rst_s_q",     64'(f1.s_q),     64'd0);
    chk("rst_co_q",    64'(f1.co_q),    64'd0);
    chk("rst_q_valid", 64'(f1.q_valid), 64'd0);
    chk("rst_w8_vld",  64'(f8.q_valid), 64'd0);

    rst = 1'b0;
    // all 8 combinations, 1-unit spacing
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {f1.a, f1.b, f1.ci} = v;
      #0.5;
      chk($sformatf("tt_s%0d", i),  64'(f1.s),  64'(s_tab[i]));
      chk($sformatf("tt_co%0d", i), 64'(f1.co), 64'(c_tab[i]));
      #0.5;
    end

    // a every 1, b every 2, ci every 4 units
    for (int t = 0; t < 16; t++) begin
      logic [3:0] v;
      v = 4'(t);
      f1.a  = v[0];
      f1.b  = v[1];
      f1.ci = v[2];
      #0.5;
      chk("tog_s",  64'(f1.s),  64'(s_tab[{v[0], v[1], v[2]}]));
      chk("tog_co", 64'(f1.co), 64'(c_tab[{v[0], v[1], v[2]}]));
      #0.5;
    end
    tick();
    chk("tog_s_q",     64'(f1.s_q),     64'd0);
    chk("tog_co_q",    64'(f1.co_q),    64'd0);
    chk("tog_q_valid", 64'(f1.q_valid), 64'd0);

    // capture 1+1+0
    f1.a = 1'b1; f1.b = 1'b1; f1.ci = 1'b0; f1.en = 1'b1;
    tick();
    chk("cap_s_q",     64'(f1.s_q),     64'd0);
    chk("cap_co_q",    64'(f1.co_q),    64'd1);
    chk("cap_q_valid", 64'(f1.q_valid), 64'd1);

    // hold with en low while inputs move
    f1.en = 1'b0;
    f1.a = 1'b0; f1.b = 1'b1; f1.ci = 1'b0;
    tick();
    tick();
    chk("hold_s",       64'(f1.s),       64'd1);
    chk("hold_co",      64'(f1.co),      64'd0);
    chk("hold_s_q",     64'(f1.s_q),     64'd0);
    chk("hold_co_q",    64'(f1.co_q),    64'd1);
    chk("hold_q_valid", 64'(f1.q_valid), 64'd1);

    // rst with en: registers clear, comb path still tracks
    rst = 1'b1;
    f1.en = 1'b1;
    f1.a = 1'b1; f1.b = 1'b1; f1.ci = 1'b1;
    tick();
    chk("pri_s_q",     64'(f1.s_q),     64'd0);
    chk("pri_co_q",    64'(f1.co_q),    64'd0);
    chk("pri_q_valid", 64'(f1.q_valid), 64'd0);
    chk("pri_s",       64'(f1.s),       64'd1);
    chk("pri_co",      64'(f1.co),      64'd1);
    rst = 1'b0;
    f1.en = 1'b0;

    // WIDTH=8 boundary vectors
    f8.a = 8'hFF; f8.b = 8'h01; f8.ci = 1'b0;
    #1;
    chk("w8_ff01_s",  64'(f8.s),  64'h00);
    chk("w8_ff01_co", 64'(f8.co), 64'd1);
    f8.a = 8'hFF; f8.b = 8'hFF; f8.ci = 1'b1;
    #1;
    chk("w8_wrap_s",  64'(f8.s),  64'hFF);
    chk("w8_wrap_co", 64'(f8.co), 64'd1);
`ifdef FA_OVF_EN
    chk("w8_wrap_ovf", 64'(f8.ovf), 64'd0);
`endif
    f8.a = 8'h3C; f8.b = 8'h5A; f8.ci = 1'b1;
    #1;
    chk("w8_mid_s",  64'(f8.s),  64'h97);
    chk("w8_mid_co", 64'(f8.co), 64'd0);
    f8.a = 8'h7F; f8.b = 8'h01; f8.ci = 1'b0;
    #1;
    chk("w8_7f01_s",  64'(f8.s),  64'h80);
    chk("w8_7f01_co", 64'(f8.co), 64'd0);
`ifdef FA_OVF_EN
    chk("w8_7f01_ovf", 64'(f8.ovf), 64'd1);
`endif
    f8.en = 1'b1;
    tick();
    f8.en = 1'b0;
    chk("w8_cap_s_q",  64'(f8.s_q),     64'h80);
    chk("w8_cap_co_q", 64'(f8.co_q),    64'd0);
    chk("w8_cap_vld",  64'(f8.q_valid), 64'd1);
`ifdef FA_OVF_EN
    chk("w8_cap_ovf_q", 64'(f8.ovf_q), 64'd1);
    f1.a = 1'b1; f1.b = 1'b1; f1.ci = 1'b0;
    #1;
    chk("w1_ovf", 64'(f1.ovf), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
